// File: rtl/fp32_div_iter.sv
// IEEE-754 binary32 divider: radix-2 restoring mantissa division, 26-cycle fixed latency.
// No denormals (flushed to zero), truncation rounding, one operation in flight.
module fp32_div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_ZERO = 2'd2;
  localparam logic [1:0] SP_INF  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [23:0] dvs;
  logic [24:0] q;
  logic        sign;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [1:0]  special;

  logic [1:0]        special_in;
  logic              rem_ge;
  logic [24:0]       rem_sel;
  logic [22:0]       mant_n;
  logic signed [9:0] exp_n;
  logic [31:0]       result_n;

  assign busy = (state != IDLE);

  // Operand classification; exp==0 counts as zero whatever the mantissa holds.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    special_in = SP_NONE;
    if (dataa[30:23] == 8'hFF || datab[30:23] == 8'hFF ||
        (dataa[30:23] == 8'h00 && datab[30:23] == 8'h00))
      special_in = SP_NAN;
    else if (dataa[30:23] == 8'h00)
      special_in = SP_ZERO;
    else if (datab[30:23] == 8'h00)
      special_in = SP_INF;
  end

  // Restoring step: the remainder stays below the divisor, so the shift never overflows.
  assign rem_ge  = (rem >= {1'b0, dvs});
  assign rem_sel = rem_ge ? (rem - {1'b0, dvs}) : rem;

  always_comb begin
    mant_n   = q[24] ? q[23:1] : q[22:0];
    exp_n    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) +
               (q[24] ? 10'sd127 : 10'sd126);
    result_n = 32'h0000_0000;
    case (special)
      SP_NAN:  result_n = 32'h7FC0_0000;
      SP_ZERO: result_n = 32'h0000_0000;
      SP_INF:  result_n = {sign, 8'hFF, 23'b0};
      default: begin
        if (exp_n >= 10'sd255)
          result_n = {sign, 8'hFF, 23'b0};
        else if (exp_n <= 10'sd0)
          result_n = 32'h0000_0000;
        else
          result_n = {sign, exp_n[7:0], mant_n};
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: datapath registers are reset too, so an aborted operation leaves no stale operands behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      rem     <= 25'd0;
      dvs     <= 24'd0;
      q       <= 25'd0;
      sign    <= 1'b0;
      exp_a   <= 8'd0;
      exp_b   <= 8'd0;
      special <= SP_NONE;
      done    <= 1'b0;
      result  <= 32'h0000_0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign    <= dataa[31] ^ datab[31];
            exp_a   <= dataa[30:23];
            exp_b   <= datab[30:23];
            special <= special_in;
            rem     <= {2'b01, dataa[22:0]};
            dvs     <= {1'b1, datab[22:0]};
            q       <= 25'd0;
            cnt     <= 5'd0;
            state   <= DIV;
          end
        end
        DIV: begin
          q   <= {q[23:0], rem_ge};
          rem <= rem_sel << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24)
            state <= NORM;
        end
        NORM: begin
          result <= result_n;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_iter.sv
// Self-checking bench for fp32_div_iter: directed corner cases, handshake/latency checks,
// mid-operation reset, and random operands scored against an integer-division reference.
module tb_fp32_div_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  fp32_div_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: quotient mantissa as floor(ma * 2^24 / mb), then the binary32 packing rules.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int              ea = int'(a[30:23]);
    int              eb = int'(b[30:23]);
    logic            s  = a[31] ^ b[31];
    longint unsigned ma = longint'({1'b1, a[22:0]});
    longint unsigned mb = longint'({1'b1, b[22:0]});
    longint unsigned qv;
    logic [22:0]     m;
    int              e;
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) return 32'h7FC0_0000;
    if (ea == 0) return 32'h0000_0000;
    if (eb == 0) return {s, 8'hFF, 23'b0};
    qv = (ma << 24) / mb;
    if (qv >= 64'h100_0000) begin
      m = 23'((qv >> 1) & 64'h7F_FFFF);
      e = ea - eb + 127;
    end else begin
      m = 23'(qv & 64'h7F_FFFF);
      e = ea - eb + 126;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0)   return 32'h0000_0000;
    return {s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          kind = int'($urandom_range(0, 9));
    logic [7:0]  e;
    logic [31:0] r = $urandom;
    if (kind == 0)      e = 8'h00;
    else if (kind == 1) e = 8'hFF;
    else                e = 8'($urandom_range(1, 254));
    return {r[31], e, r[22:0]};
  endfunction

  // Called #1 after a clock edge; the next edge is E0. Returns #1 after E26.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                        input string tag, input bit noise);
    int ndone = 0;
    start = 1'b1;
    dataa = a;
    datab = b;
    @(posedge clk); #1;
    start = 1'b0;
    dataa = $urandom;
    datab = $urandom;
    check({tag, "_busy_e0"}, {31'b0, busy}, 32'd1);
    check({tag, "_done_e0"}, {31'b0, done}, 32'd0);
    for (int e = 1; e <= 25; e++) begin
      if (noise && (e == 5 || e == 20)) begin
        start = 1'b1;
        dataa = $urandom;
        datab = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) ndone++;
    end
    check({tag, "_early_done"}, 32'(ndone), 32'd0);
    check({tag, "_busy_e25"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_e26"}, {31'b0, done}, 32'd1);
    check({tag, "_busy_e26"}, {31'b0, busy}, 32'd0);
    check({tag, "_result"}, result, want);
  endtask

  task automatic gap(input string tag, input logic [31:0] want);
    @(posedge clk); #1;
    check({tag, "_done_clr"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, result, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
    int          ndone;

    reset = 1'b1;
    start = 1'b0;
    dataa = 32'h0;
    datab = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "six_by_two", 1'b0);
    gap("six_by_two", 32'h4040_0000);
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, "one_third", 1'b0);
    gap("one_third", 32'h3EAA_AAAA);
    run_op(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, "neg_7p5", 1'b0);
    gap("neg_7p5", 32'hC040_0000);
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "div_zero", 1'b0);
    gap("div_zero", 32'h7F80_0000);
    run_op(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, "zero_num", 1'b0);
    gap("zero_num", 32'h0000_0000);
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, "zero_zero", 1'b0);
    gap("zero_zero", 32'h7FC0_0000);
    run_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, "overflow", 1'b0);
    gap("overflow", 32'h7F80_0000);
    run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, "underflow", 1'b0);
    gap("underflow", 32'h0000_0000);

    // Starts at E5/E20 must be dropped: one done, result from the original operands.
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "noise", 1'b1);
    gap("noise", 32'h4040_0000);
    check("noise_idle_busy", {31'b0, busy}, 32'd0);

    // Back-to-back: the second E0 is the first operation's E27.
    run_op(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, "b2b_first", 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, "b2b_second", 1'b0);
    gap("b2b_second", 32'h3EAA_AAAA);

    for (int i = 0; i < 40; i++) begin
      a = rand_fp();
      b = rand_fp();
      w = ref_div(a, b);
      run_op(a, b, w, $sformatf("rnd%0d_%h_%h", i, a, b), (i % 4) == 3);
      if (i % 2 == 0) gap($sformatf("rnd%0d", i), w);
    end

    // Reset at E10 aborts the operation at once and suppresses its done.
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "pre_abort", 1'b0);
    gap("pre_abort", 32'h4040_0000);
    start = 1'b1;
    dataa = 32'h3F80_0000;
    datab = 32'h4040_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_idle", {31'b0, busy}, 32'd0);
    run_op(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, "post_abort", 1'b0);
    gap("post_abort", 32'hC040_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
